// File: rtl/rx_pkg.sv
// Shared definitions for the receive-path FCS checker: CRC-32 constants,
// the checker FSM state type and small pure helpers.
package rx_pkg;

  // IEEE 802.3 CRC-32 generator, preset and good-frame residue (MSB-first form)
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rx_state_t;

  // Mirror a byte so the first serial bit (bit 0) lands on the MSB
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7 - i];
    end
    return r;
  endfunction

  // Frame length outside the legal window (counts include the FCS)
  function automatic logic len_out_of_range(input logic [15:0] cnt,
                                            input int        min_len,
                                            input int        max_len);
    int cnt_i;
    cnt_i = int'({16'd0, cnt});
    return (cnt_i < min_len) || (cnt_i > max_len);
  endfunction

endpackage

// File: rtl/rx_crc_check_crc32_byte_step.sv
// crc32_byte_step: combinational CRC-32 next state for one byte.
// The byte is consumed MSB first, so data_byte[7] is the first serial bit.
module crc32_byte_step
  import rx_pkg::*;
(
  input  logic [31:0] crc_cur,
  input  logic [7:0]  data_byte,
  output logic [31:0] crc_next
);

  logic [31:0] crc_s;

  // Eight serial LFSR shifts unrolled into one combinational step
  always_comb begin
    crc_s = crc_cur;
    for (int i = 7; i >= 0; i--) begin
      if ((crc_s[31] ^ data_byte[i]) == 1'b1) begin
        crc_s = {crc_s[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        crc_s = {crc_s[30:0], 1'b0};
      end
    end
  end

  assign crc_next = crc_s;

endmodule

// File: rtl/rx_crc_check.sv
// rx_crc_check: byte-serial Ethernet FCS checker for the receive path.
// Runs CRC-32 over DA..FCS and reports a registered verdict one cycle after
// the EOF (or aborting SOF) byte.
// Optional feature macro: RX_CRC_LEN_CHECK_EN (frame length window check on
// len_err); when undefined len_err is tied low and no comparators exist.
module rx_crc_check
  import rx_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  output logic        crc_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic [15:0] byte_count,
  output logic        len_err
);

  rx_state_t   state_r;
  logic [31:0] crc_r;
  logic [15:0] cnt_r;          // running count of the frame in progress
  logic [15:0] byte_count_r;   // reported count (final count in the verdict cycle)
  logic        done_r;
  logic        ok_r;
  logic        err_r;

  logic [31:0] crc_seed_s;
  logic [31:0] crc_next_s;
  logic [7:0]  data_rev_s;
  logic [15:0] cnt_inc_s;

  assign data_rev_s = bit_rev8(rx_data);

  // Saturating increment of the running byte count
  always_comb begin
    if (cnt_r == 16'hFFFF) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + 16'd1;
    end
  end

  // A SOF byte always starts from the preset, whatever state we are in
  always_comb begin
    if (rx_valid && rx_sof) begin
      crc_seed_s = CRC32_INIT;
    end else begin
      crc_seed_s = crc_r;
    end
  end

  crc32_byte_step u_step (
    .crc_cur   (crc_seed_s),
    .data_byte (data_rev_s),
    .crc_next  (crc_next_s)
  );

  // Frame FSM, CRC register, byte counters and verdict registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      crc_r        <= CRC32_INIT;
      cnt_r        <= 16'd0;
      byte_count_r <= 16'd0;
      done_r       <= 1'b0;
      ok_r         <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        // DONE accepts a new SOF exactly like IDLE, giving zero-gap frames
        IDLE, DONE: begin
          if (rx_valid && rx_sof) begin
            crc_r        <= crc_next_s;
            cnt_r        <= 16'd1;
            byte_count_r <= 16'd1;
            if (rx_eof) begin
              // A single byte can never carry a valid FCS
              state_r <= DONE;
              done_r  <= 1'b1;
              ok_r    <= 1'b0;
              err_r   <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (rx_valid && rx_sof) begin
            // Abort: fail the old frame, report its length, restart on this byte.
            // A SOF+EOF byte here folds into the same error verdict.
            done_r       <= 1'b1;
            ok_r         <= 1'b0;
            err_r        <= 1'b1;
            byte_count_r <= cnt_r;
            cnt_r        <= 16'd1;
            crc_r        <= crc_next_s;
            if (rx_eof) begin
              state_r <= DONE;
            end else begin
              state_r <= RUN;
            end
          end else if (rx_valid) begin
            crc_r        <= crc_next_s;
            cnt_r        <= cnt_inc_s;
            byte_count_r <= cnt_inc_s;
            if (rx_eof) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              ok_r    <= (crc_next_s == CRC32_RESIDUE);
              err_r   <= (crc_next_s != CRC32_RESIDUE);
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef RX_CRC_LEN_CHECK_EN
  logic        len_evt_s;
  logic [15:0] len_cnt_s;
  logic        len_err_r;

  // Which count gets judged, and whether a verdict is issued this cycle
  always_comb begin
    len_evt_s = 1'b0;
    len_cnt_s = 16'd0;
    case (state_r)
      RUN: begin
        if (rx_valid && rx_sof) begin
          len_evt_s = 1'b1;
          len_cnt_s = cnt_r;
        end else if (rx_valid && rx_eof) begin
          len_evt_s = 1'b1;
          len_cnt_s = cnt_inc_s;
        end else begin
          len_evt_s = 1'b0;
          len_cnt_s = 16'd0;
        end
      end
      IDLE, DONE: begin
        if (rx_valid && rx_sof && rx_eof) begin
          len_evt_s = 1'b1;
          len_cnt_s = 16'd1;
        end else begin
          len_evt_s = 1'b0;
          len_cnt_s = 16'd0;
        end
      end
      default: begin
        len_evt_s = 1'b0;
        len_cnt_s = 16'd0;
      end
    endcase
  end

  // Length verdict, updated together with crc_done and held like crc_ok
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_err_r <= 1'b0;
    end else if (len_evt_s) begin
      len_err_r <= len_out_of_range(len_cnt_s, MIN_LEN, MAX_LEN);
    end else begin
      len_err_r <= len_err_r;
    end
  end

  assign len_err = len_err_r;
`else
  assign len_err = 1'b0;
`endif

  assign crc_done   = done_r;
  assign crc_ok     = ok_r;
  assign crc_err    = err_r;
  assign byte_count = byte_count_r;

endmodule

// File: tb/tb_rx_crc_check.sv
// Self-checking bench for rx_crc_check. The reference model is a reflected
// (LSB-first) CRC-32 over the payload compared with the appended FCS.
module tb_rx_crc_check;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic        ok;
    logic        err;
    logic [15:0] cnt;
    logic        len;
    int          cyc;
  } verdict_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_sof = 1'b0;
  logic        rx_eof = 1'b0;
  logic        crc_done;
  logic        crc_ok;
  logic        crc_err;
  logic [15:0] byte_count;
  logic        len_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  verdict_t got_q[$];
  verdict_t exp_q[$];

  rx_crc_check #(.MAX_LEN(1518), .MIN_LEN(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .rx_eof     (rx_eof),
    .crc_done   (crc_done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .byte_count (byte_count),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every verdict pulse away from the active edge
  always @(negedge clk) begin
    verdict_t mv;
    if (crc_done === 1'b1) begin
      mv.ok  = crc_ok;
      mv.err = crc_err;
      mv.cnt = byte_count;
      mv.len = len_err;
      mv.cyc = cyc;
      got_q.push_back(mv);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_crc(input byte_q_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) begin
        if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
        else      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic bit frame_good(input byte_q_t fr);
    int n;
    n = fr.size();
    if (n < 4) return 1'b0;
    return ref_crc(fr, n - 4) == {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t d);
    byte_q_t r;
    logic [31:0] c;
    r = d;
    c = ref_crc(d, d.size());
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    r.push_back(c[23:16]);
    r.push_back(c[31:24]);
    return r;
  endfunction

  function automatic logic exp_len(input int n);
`ifdef RX_CRC_LEN_CHECK_EN
    return (n < 64) || (n > 1518);
`else
    return 1'b0;
`endif
  endfunction

  function automatic verdict_t mk_exp(input logic ok, input int n, input int at);
    verdict_t v;
    v.ok  = ok;
    v.err = ~ok;
    v.cnt = (n > 65535) ? 16'hFFFF : 16'(n);
    v.len = exp_len(n);
    v.cyc = at;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_byte(input logic [7:0] d, input logic sof, input logic eof);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_sof   = sof;
    rx_eof   = eof;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_eof   = 1'b0;
  endtask

  task automatic drive_gap();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    rx_sof   = 1'($urandom_range(0, 1));
    rx_eof   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    rx_sof = 1'b0;
    rx_eof = 1'b0;
  endtask

  // Send a whole frame with gaps randomly placed between its bytes
  task automatic send_frame(input byte_q_t fr, input int gaps);
    int n;
    int gap_at[];
    n = fr.size();
    gap_at = new[n];
    for (int i = 0; i < n; i++) gap_at[i] = 0;
    if (n > 1) begin
      for (int g = 0; g < gaps; g++) gap_at[$urandom_range(1, n - 1)]++;
    end
    for (int i = 0; i < n; i++) begin
      repeat (gap_at[i]) drive_gap();
      if (i == n - 1) exp_q.push_back(mk_exp(frame_good(fr), n, cyc + 1));
      drive_byte(fr[i], i == 0, i == n - 1);
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({crc_done, crc_ok, crc_err, byte_count, len_err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_hold got done=%b ok=%b err=%b cnt=%0d len=%b want all 0",
               crc_done, crc_ok, crc_err, byte_count, len_err);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({crc_done, crc_ok, crc_err, byte_count, len_err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_release got done=%b ok=%b err=%b cnt=%0d len=%b want all 0",
               crc_done, crc_ok, crc_err, byte_count, len_err);
    end
    got_q.delete();
  endtask

  task automatic test_known_good();
    byte_q_t fr;
    verdict_t gv, ev;
    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    exp_q.push_back(mk_exp(1'b1, 13, cyc + 13));
    for (int i = 0; i < 13; i++) drive_byte(fr[i], i == 0, i == 12);
    repeat (3) drive_gap();
    checks++;
    if (crc_ok !== 1'b1 || crc_err !== 1'b0 || crc_done !== 1'b0) begin
      errors++;
      $display("FAIL good_hold got ok=%b err=%b done=%b want ok=1 err=0 done=0",
               crc_ok, crc_err, crc_done);
    end
    fr[12] = 8'hCA;
    exp_q.push_back(mk_exp(1'b0, 13, cyc + 13));
    for (int i = 0; i < 13; i++) drive_byte(fr[i], i == 0, i == 12);
    exp_q.push_back(mk_exp(1'b0, 1, cyc + 1));
    drive_byte(8'hA5, 1'b1, 1'b1);
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL known_good_count got %0d verdicts want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gv = got_q.pop_front();
      ev = exp_q.pop_front();
      checks++;
      if (gv !== ev) begin
        errors++;
        $display("FAIL known_good got ok=%b err=%b cnt=%0d len=%b cyc=%0d want ok=%b err=%b cnt=%0d len=%b cyc=%0d",
                 gv.ok, gv.err, gv.cnt, gv.len, gv.cyc, ev.ok, ev.err, ev.cnt, ev.len, ev.cyc);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_gaps_back_to_back();
    byte_q_t fr;
    verdict_t gv, ev;
    fr = with_fcs('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39});
    send_frame(fr, 3);
    send_frame(fr, 0);
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d verdicts want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gv = got_q.pop_front();
      ev = exp_q.pop_front();
      checks++;
      if (gv !== ev) begin
        errors++;
        $display("FAIL b2b got ok=%b err=%b cnt=%0d len=%b cyc=%0d want ok=%b err=%b cnt=%0d len=%b cyc=%0d",
                 gv.ok, gv.err, gv.cnt, gv.len, gv.cyc, ev.ok, ev.err, ev.cnt, ev.len, ev.cyc);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_abort();
    byte_q_t fr;
    verdict_t gv, ev;
    for (int i = 0; i < 6; i++) drive_byte(8'($urandom), i == 0, 1'b0);
    exp_q.push_back(mk_exp(1'b0, 6, cyc + 1));
    fr = with_fcs('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39});
    send_frame(fr, 0);
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_count got %0d verdicts want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gv = got_q.pop_front();
      ev = exp_q.pop_front();
      checks++;
      if (gv !== ev) begin
        errors++;
        $display("FAIL abort got ok=%b err=%b cnt=%0d len=%b cyc=%0d want ok=%b err=%b cnt=%0d len=%b cyc=%0d",
                 gv.ok, gv.err, gv.cnt, gv.len, gv.cyc, ev.ok, ev.err, ev.cnt, ev.len, ev.cyc);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t fr;
    verdict_t gv, ev;
    for (int i = 0; i < 4; i++) drive_byte(8'($urandom), i == 0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({crc_done, crc_ok, crc_err, byte_count, len_err} !== 20'd0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid got done=%b ok=%b err=%b cnt=%0d len=%b verdicts=%0d want all 0",
               crc_done, crc_ok, crc_err, byte_count, len_err, got_q.size());
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    fr = with_fcs('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39});
    send_frame(fr, 1);
    settle();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL reset_mid_count got %0d verdicts want 1", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gv = got_q.pop_front();
      ev = exp_q.pop_front();
      checks++;
      if (gv !== ev) begin
        errors++;
        $display("FAIL reset_mid got ok=%b err=%b cnt=%0d len=%b cyc=%0d want ok=%b err=%b cnt=%0d len=%b cyc=%0d",
                 gv.ok, gv.err, gv.cnt, gv.len, gv.cyc, ev.ok, ev.err, ev.cnt, ev.len, ev.cyc);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_length();
    byte_q_t d;
    verdict_t gv, ev;
    int lens[4] = '{64, 63, 1518, 1519};
    foreach (lens[j]) begin
      d.delete();
      for (int i = 0; i < lens[j] - 4; i++) d.push_back((j == 0) ? 8'h00 : 8'($urandom));
      send_frame(with_fcs(d), 0);
    end
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL length_count got %0d verdicts want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gv = got_q.pop_front();
      ev = exp_q.pop_front();
      checks++;
      if (gv !== ev) begin
        errors++;
        $display("FAIL length got ok=%b err=%b cnt=%0d len=%b cyc=%0d want ok=%b err=%b cnt=%0d len=%b cyc=%0d",
                 gv.ok, gv.err, gv.cnt, gv.len, gv.cyc, ev.ok, ev.err, ev.cnt, ev.len, ev.cyc);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    byte_q_t d, fr;
    verdict_t gv, ev;
    int n, idx;
    for (int f = 0; f < 30; f++) begin
      d.delete();
      if ($urandom_range(0, 9) == 0) begin
        fr = '{8'($urandom)};
      end else begin
        n = $urandom_range(1, 76);
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        fr = with_fcs(d);
        if ($urandom_range(0, 1) == 1) begin
          idx = $urandom_range(0, fr.size() - 1);
          fr[idx] = fr[idx] ^ (8'd1 << $urandom_range(0, 7));
        end
      end
      send_frame(fr, $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: ;
        1: drive_gap();
        default: drive_byte(8'($urandom), 1'b0, 1'b0);
      endcase
    end
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d verdicts want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gv = got_q.pop_front();
      ev = exp_q.pop_front();
      checks++;
      if (gv !== ev) begin
        errors++;
        $display("FAIL random got ok=%b err=%b cnt=%0d len=%b cyc=%0d want ok=%b err=%b cnt=%0d len=%b cyc=%0d",
                 gv.ok, gv.err, gv.cnt, gv.len, gv.cyc, ev.ok, ev.err, ev.cnt, ev.len, ev.cyc);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_known_good();
    test_gaps_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_length();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
